// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM states, requester ids, response tag.
// No logic; no latency.
// No flow control.
package ram_arbiter_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/round_robin_arbiter_2.sv
// Two-way round-robin arbiter with a registered priority bit, one-hot grant.
// Latency: grant is combinational from the request lines.
// Backpressure: enable=0 suppresses all grants; priority only moves on a grant.
module round_robin_arbiter_2
    import ram_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       req_a,
    input  logic       req_b,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req_a && (!req_b || prio == REQ_A)) begin
                grant[0] = 1'b1;
            end else if (req_b) begin
                grant[1] = 1'b1;
            end
        end
    end

    // The winner of each grant yields priority to the other requester.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio <= REQ_A;
        end else if (grant[0]) begin
            prio <= REQ_B;
        end else if (grant[1]) begin
            prio <= REQ_A;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Zero-fills a single-port RAM after reset, then arbitrates two requesters onto it.
// Latency: grant same cycle as valid; read data returned one cycle after the transfer.
// Backpressure: ready withheld during fill or when the other side wins; responses cannot stall.
module ram_port_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     a_req_valid,
    output logic                     a_req_ready,
    input  logic                     a_req_write,
    input  logic [ADDRESS_WIDTH-1:0] a_req_address,
    input  logic [DATA_WIDTH-1:0]    a_req_write_data,
    output logic                     a_rsp_valid,
    output logic [DATA_WIDTH-1:0]    a_rsp_data,
    input  logic                     b_req_valid,
    output logic                     b_req_ready,
    input  logic                     b_req_write,
    input  logic [ADDRESS_WIDTH-1:0] b_req_address,
    input  logic [DATA_WIDTH-1:0]    b_req_write_data,
    output logic                     b_rsp_valid,
    output logic [DATA_WIDTH-1:0]    b_rsp_data,
    output logic                     init_busy,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_write_data,
    output logic                     ram_write_enable,
    input  logic [DATA_WIDTH-1:0]    ram_read_data
);

    arb_state_t               state;
    arb_state_t               next_state;
    logic [ADDRESS_WIDTH-1:0] init_cnt;
    logic [1:0]               grant;
    logic                     arb_enable;
    logic                     fill_drive;
    rsp_tag_t                 rsp_tag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= (INIT_ON_RESET != 0) ? INIT : SERVE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == INIT && init_cnt == {ADDRESS_WIDTH{1'b1}}) begin
            next_state = SERVE;
        end
    end

    // Gating with reset_n keeps the RAM write strobe and grants quiet while reset is held.
    always_comb begin
        init_busy  = (state == INIT);
        fill_drive = (state == INIT) && reset_n;
        arb_enable = (state == SERVE) && reset_n;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    round_robin_arbiter_2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (arb_enable),
        .req_a   (a_req_valid),
        .req_b   (b_req_valid),
        .grant   (grant)
    );

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];

    always_comb begin
        ram_address      = '0;
        ram_write_data   = '0;
        ram_write_enable = 1'b0;
        if (fill_drive) begin
            ram_address      = init_cnt;
            ram_write_enable = 1'b1;
        end else if (grant[0]) begin
            ram_address      = a_req_address;
            ram_write_data   = a_req_write_data;
            ram_write_enable = a_req_write;
        end else if (grant[1]) begin
            ram_address      = b_req_address;
            ram_write_data   = b_req_write_data;
            ram_write_enable = b_req_write;
        end
    end

    // Tag follows the RAM's one-cycle read so the data is steered to whoever asked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_tag <= '0;
        end else begin
            rsp_tag.valid <= (grant[0] && !a_req_write) || (grant[1] && !b_req_write);
            rsp_tag.id    <= grant[1] ? REQ_B : REQ_A;
        end
    end

    assign a_rsp_valid = rsp_tag.valid && (rsp_tag.id == REQ_A);
    assign b_rsp_valid = rsp_tag.valid && (rsp_tag.id == REQ_B);
    assign a_rsp_data  = a_rsp_valid ? ram_read_data : '0;
    assign b_rsp_data  = b_rsp_valid ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural RAM and a scoreboard of read responses.
// Stimulus issued on the falling edge; responses checked by an independent monitor.
// Requests are held until granted.
module tb_ram_port_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req_valid = 1'b0, a_req_write = 1'b0;
    logic [AW-1:0] a_req_address = '0;
    logic [DW-1:0] a_req_write_data = '0;
    logic          b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [AW-1:0] b_req_address = '0;
    logic [DW-1:0] b_req_write_data = '0;
    logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, init_busy;
    logic [DW-1:0] a_rsp_data, b_rsp_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_write_data, ram_read_data;
    logic          ram_write_enable;

    always #5 clock = ~clock;

    ram_port_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_address(a_req_address), .a_req_write_data(a_req_write_data),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_address(b_req_address), .b_req_write_data(b_req_write_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .init_busy(init_busy), .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_enable(ram_write_enable), .ram_read_data(ram_read_data)
    );

    // Behavioural single-port RAM with a registered read port.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_write_data;
        ram_read_data <= ram_mem[ram_address];
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q [2][$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          model_prio;
    logic          last_ga, last_gb;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        logic          rv [2];
        logic [DW-1:0] rd [2];
        exp_t          e;
        string         who;
        if (mon_en) begin
            rv[0] = a_rsp_valid; rd[0] = a_rsp_data;
            rv[1] = b_rsp_valid; rd[1] = b_rsp_data;
            for (int r = 0; r < 2; r++) begin
                who = (r == 0) ? "a" : "b";
                if (rv[r] === 1'b1) begin
                    if (exp_q[r].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected_%s: got valid with data %0h expected no response (cycle %0d)",
                                 who, rd[r], cyc);
                    end else begin
                        e = exp_q[r].pop_front();
                        chk({"rsp_data_", who}, rd[r], e.data);
                        chk({"rsp_cycle_", who}, cyc, e.due);
                    end
                end else begin
                    chk({"rsp_data_idle_", who}, rd[r], 0);
                    if (exp_q[r].size() != 0 && exp_q[r][0].due <= cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_missing_%s: got no response expected data %0h due cycle %0d (cycle %0d)",
                                 who, exp_q[r][0].data, exp_q[r][0].due, cyc);
                        void'(exp_q[r].pop_front());
                    end
                end
            end
        end
    end

    task automatic apply(input int r, input logic w, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        chk("ram_address", ram_address, addr);
        chk("ram_write_enable", ram_write_enable, w);
        if (w) begin
            chk("ram_write_data", ram_write_data, data);
            ref_mem[addr] = data;
        end else begin
            exp_q[r].push_back('{data: ref_mem[addr], due: cyc + 1});
        end
        model_prio = (r == 0) ? 1'b1 : 1'b0;
    endtask

    task automatic drive(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        logic ea, eb;
        @(negedge clock);
        a_req_valid = av; a_req_write = aw; a_req_address = aa; a_req_write_data = ad;
        b_req_valid = bv; b_req_write = bw; b_req_address = ba; b_req_write_data = bd;
        #1;
        // Lone requester wins; on contention the side holding priority wins.
        ea = av && (!bv || model_prio == 1'b0);
        eb = bv && !ea;
        chk("a_req_ready", a_req_ready, ea);
        chk("b_req_ready", b_req_ready, eb);
        if (ea) apply(0, aw, aa, ad);
        else if (eb) apply(1, bw, ba, bd);
        else begin
            chk("idle_write_enable", ram_write_enable, 0);
            chk("idle_address", ram_address, 0);
        end
        last_ga = ea;
        last_gb = eb;
    endtask

    task automatic run_init(input int abort_at);
        mon_en = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        reset_n = 1'b0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_address = 9;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_address = 9;
        #1;
        chk("rst_a_req_ready", a_req_ready, 0);
        chk("rst_b_req_ready", b_req_ready, 0);
        chk("rst_a_rsp_valid", a_rsp_valid, 0);
        chk("rst_b_rsp_valid", b_rsp_valid, 0);
        chk("rst_a_rsp_data", a_rsp_data, 0);
        chk("rst_b_rsp_data", b_rsp_data, 0);
        chk("rst_ram_write_enable", ram_write_enable, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_write_data", ram_write_data, 0);
        chk("rst_init_busy", init_busy, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            chk("init_busy", init_busy, 1);
            chk("init_address", ram_address, i);
            chk("init_write_enable", ram_write_enable, 1);
            chk("init_write_data", ram_write_data, 0);
            chk("init_a_req_ready", a_req_ready, 0);
            chk("init_b_req_ready", b_req_ready, 0);
            chk("init_a_rsp_valid", a_rsp_valid, 0);
            if (i == abort_at) return;
        end
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        model_prio = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic post_init_read();
        drive(1, 0, 9, 0, 0, 0, 0, 0);
        chk("init_busy_clear", init_busy, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic          pv [2], pw [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        for (int k = 0; k < DEPTH; k++) ram_mem[k] = 8'($urandom_range(1, 255));

        run_init(-1);
        post_init_read();

        drive(1, 1, 9, 9, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 9, 0);
        drive(1, 1, 21, 21, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 27, 27);
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 21, 0, 1, 0, 27, 0);
            chk("alternate_grant_a", a_req_ready, (k % 2 == 0) ? 1 : 0);
        end
        drive(1, 1, 27, 27, 1, 0, 27, 0);
        chk("same_cycle_a_first", a_req_ready, 1);
        drive(0, 0, 0, 0, 1, 0, 27, 0);
        chk("same_cycle_b_next", b_req_ready, 1);
        for (int k = 0; k < 4; k++) drive(1, 0, 6'(k), 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);

        drive(1, 0, 21, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        run_init(-1);
        post_init_read();

        run_init(20);
        run_init(-1);
        post_init_read();

        pv[0] = 1'b0; pv[1] = 1'b0;
        pw[0] = 1'b0; pw[1] = 1'b0;
        pa[0] = '0;   pa[1] = '0;
        pd[0] = '0;   pd[1] = '0;
        repeat (600) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 3) != 0) begin
                    pv[r] = 1'b1;
                    pw[r] = 1'($urandom_range(0, 1));
                    pa[r] = 6'($urandom_range(0, 7));
                    pd[r] = 8'($urandom_range(0, 255));
                end
            end
            drive(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1]);
            if (last_ga) pv[0] = 1'b0;
            if (last_gb) pv[1] = 1'b0;
        end
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("responses_drained", exp_q[0].size() + exp_q[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter and initialiser for the 64x8 single-port RAM. It sits directly in front of `single_port_RAM` and drives its `address`, `write_data` and `write_enable` inputs. It returns `read_data` to whichever requester issued the read. After reset it zero-fills the whole RAM, then grants at most one request per cycle with valid/ready handshakes.

## Interface
- `ADDRESS_WIDTH`, 6: RAM address width; depth = 2^ADDRESS_WIDTH.
- `DATA_WIDTH`, 8: RAM word width.
- `INIT_ON_RESET`, 1: 1 = zero-fill the RAM after reset; 0 = go straight to serving requests.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req_valid`  in  1  requester A has a request.
- `a_req_ready`  out  1  A's request is granted this cycle.
- `a_req_write`  in  1  1 = write, 0 = read.
- `a_req_address`  in  ADDRESS_WIDTH  request address.
- `a_req_write_data`  in  DATA_WIDTH  write data.
- `a_rsp_valid`  out  1  read data for A is valid.
- `a_rsp_data`  out  DATA_WIDTH  read data; 0 when `a_rsp_valid`=0.
- `b_*`: identical set of seven ports for requester B.
- `init_busy`  out  1  zero-fill in progress; no grants.
- `ram_address`  out  ADDRESS_WIDTH  to RAM `address`.
- `ram_write_data`  out  DATA_WIDTH  to RAM `write_data`.
- `ram_write_enable`  out  1  to RAM `write_enable`.
- `ram_read_data`  in  DATA_WIDTH  from RAM `read_data`.

## Operation
- State machine states: INIT and SERVE.
  - Reset enters INIT if `INIT_ON_RESET`=1, otherwise SERVE.
- INIT:
  - Counter runs 0 to 2^ADDRESS_WIDTH-1.
  - Each cycle drives `ram_address`=counter, `ram_write_data`=0, `ram_write_enable`=1.
  - `init_busy`=1, and both `*_req_ready`=0.
  - On the last address, the FSM moves to SERVE on the next edge.
- SERVE, grant rules:
  - Grant logic is combinational from `*_req_valid` and a registered priority bit.
  - Only one requester valid: it is granted.
  - Both valid: the requester holding priority is granted.
  - After any grant, priority moves to the other requester.
  - Reset gives priority to A.
- SERVE, RAM drive:
  - Granted request is muxed onto the `ram_*` outputs; `ram_write_enable` = granted `req_write`.
  - No grant: `ram_write_enable`=0 and `ram_address`=0.
- A transfer occurs when `req_valid`=1 and `req_ready`=1 on the same edge.
- Read response:
  - A registered tag (valid plus requester id) records each granted read.
  - Next cycle, the tagged requester sees `rsp_valid`=1 and `rsp_data`=`ram_read_data`.
  - Responses cannot be backpressured; requesters must accept them.
- Writes produce no response.
- A write and a read to the same address in the same cycle are serialised by arbitration order. A read granted after the write returns the new data.
- `req_*` fields must stay stable while `valid`=1 and `ready`=0.
- Reset asserted mid-INIT or mid-transfer:
  - Clears the FSM, counter, priority and response tag immediately.
  - An in-flight read response is dropped.
  - INIT restarts from address 0.

## Timing
- Reset values:
  - `*_req_ready`=0, `*_rsp_valid`=0, `*_rsp_data`=0.
  - `ram_write_enable`=0, `ram_address`=0, `ram_write_data`=0.
  - `init_busy`=1 if `INIT_ON_RESET`, else 0.
- INIT length: exactly 2^ADDRESS_WIDTH cycles after `reset_n` deasserts. The first grant is possible in cycle 2^ADDRESS_WIDTH (counting from 0).
- Read latency: 1 cycle. A read transferred in cycle N gives `rsp_valid` in cycle N+1.
- Throughput: one transfer per cycle. Back-to-back reads from one requester give responses on consecutive cycles, in order.
- `ready` is combinational from `valid` (valid-to-ready path). `rsp_valid` is registered. `rsp_data` is a gated passthrough of `ram_read_data`.

## Structure
- Shared package `ram_arbiter_pkg`:
  - State enum {INIT, SERVE}.
  - Requester id constants REQ_A=0, REQ_B=1.
  - Response tag struct {valid, id}.
- Sub-module `round_robin_arbiter_2`:
  - Inputs: two request lines, an enable, clock and reset_n.
  - Outputs: one-hot grant.
  - Owns the priority bit.
  - Enable=0 during INIT.
- Top level holds the FSM, init counter, request mux and response tag.

## Test plan
- Reset with `INIT_ON_RESET`=1:
  - `init_busy` is high for 64 cycles.
  - 64 writes of 0 to addresses 0..63 appear on the `ram_*` outputs.
  - A then reads address 9 → `a_rsp_data`=0.
- A writes 9 to address 9; next cycle B reads address 9:
  - `b_rsp_valid`=1 one cycle after B's transfer, `b_rsp_data`=9.
  - `a_rsp_valid` stays 0 throughout.
- A and B both hold valid for 6 cycles (reads of addresses 21 and 27, preloaded with 21 and 27):
  - Grants alternate A,B,A,B,A,B.
  - Responses alternate 21,27,… each one cycle later.
- Same cycle, A writes 27 to address 27 and B reads address 27:
  - A is granted first (priority), B in the next cycle.
  - `b_rsp_data`=27.
- `reset_n` pulsed low at init count 20:
  - All outputs go to their reset values immediately.
  - INIT restarts at address 0 and `init_busy` lasts a full 64 cycles after release.
- A reads addresses 0..3 back-to-back with B idle:
  - 4 consecutive grants.
  - `a_rsp_valid` high for 4 consecutive cycles with data in order.
